// File: rtl/pixel_stream_writer_pkg.sv
// Shared definitions for the pixel stream writer and the panel driver.
// Holds the byte-packer state encoding, the write mask and the frame size helper.
package pixel_stream_writer_pkg;

  localparam logic [2:0] ST_WAIT_SOF = 3'd0;
  localparam logic [2:0] ST_GET_R    = 3'd1;
  localparam logic [2:0] ST_GET_G    = 3'd2;
  localparam logic [2:0] ST_GET_B    = 3'd3;
  localparam logic [2:0] ST_DROP     = 3'd4;

  localparam logic [3:0] WR_ALL = 4'b0111;

  function automatic int pixel_count(input int chained);
    return chained * 128;
  endfunction

endpackage

// File: rtl/pixel_stream_writer_rgb_byte_packer.sv
// Collects R,G,B stream bytes into one 24-bit pixel and flags start-of-frame events.
// state    | meaning
// WAIT_SOF | idle after reset, discarding bytes until a start-of-frame
// GET_R    | expecting the R byte of the next pixel
// GET_G    | R latched, expecting G
// GET_B    | R and G latched, expecting B
// DROP     | frame complete, discarding bytes until the next start-of-frame
module rgb_byte_packer
  import pixel_stream_writer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_sof,
  input  logic        last_pix,
  output logic        pix_valid,
  output logic [23:0] pix_data,
  output logic        sof_start,
  output logic        sof_mid,
  output logic        sof_in_r
);

  logic [2:0] state;
  logic [7:0] r_q;
  logic [7:0] g_q;
  logic       accept;

  assign accept = in_valid && ready;

  always_comb begin
    pix_valid = accept && !in_sof && (state == ST_GET_B);
    pix_data  = {r_q, g_q, in_data};
    sof_start = accept && in_sof;
    sof_mid   = sof_start && ((state == ST_GET_G) || (state == ST_GET_B));
    sof_in_r  = sof_start && (state == ST_GET_R);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_WAIT_SOF;
      r_q   <= 8'd0;
      g_q   <= 8'd0;
    end else if (accept) begin
      if (in_sof) begin
        r_q   <= in_data;
        state <= ST_GET_G;
      end else begin
        case (state)
          ST_GET_R: begin
            r_q   <= in_data;
            state <= ST_GET_G;
          end
          ST_GET_G: begin
            g_q   <= in_data;
            state <= ST_GET_B;
          end
          ST_GET_B: state <= last_pix ? ST_DROP : ST_GET_R;
          default:  state <= state;
        endcase
      end
    end
  end

endmodule

// File: rtl/pixel_stream_writer.sv
// Turns an RGB888 byte stream into linear-address pixel writes for the panel video memory.
// Also reports completed and aborted frames to the control CPU.
module pixel_stream_writer
  import pixel_stream_writer_pkg::*;
#(
  parameter int CHAINED     = 3,
  parameter int INPUT_DEPTH = 6
) (
  input  logic        ctrl_clk,
  input  logic        ctrl_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_sof,
  output logic        ctrl_en,
  output logic [3:0]  ctrl_wr,
  output logic [15:0] ctrl_addr,
  output logic [23:0] ctrl_wdat,
  output logic        frame_done,
  output logic        frame_short,
  output logic [15:0] frame_count
);

  localparam logic [15:0] LAST_IDX = 16'(pixel_count(CHAINED) - 1);

  logic [15:0] pix_idx;
  logic        last_pix;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        sof_start;
  logic        sof_mid;
  logic        sof_in_r;

  // Keep the top INPUT_DEPTH bits of a channel, right-justified.
  function automatic logic [7:0] reduce_ch(input logic [7:0] c);
    return c >> (8 - INPUT_DEPTH);
  endfunction

  assign last_pix = (pix_idx == LAST_IDX);

  rgb_byte_packer u_packer (
    .clk       (ctrl_clk),
    .rst       (ctrl_rst),
    .ready     (in_ready),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .last_pix  (last_pix),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .sof_start (sof_start),
    .sof_mid   (sof_mid),
    .sof_in_r  (sof_in_r)
  );

  always_ff @(posedge ctrl_clk or posedge ctrl_rst) begin
    if (ctrl_rst) begin
      in_ready    <= 1'b0;
      pix_idx     <= 16'd0;
      ctrl_en     <= 1'b0;
      ctrl_wr     <= 4'b0000;
      ctrl_addr   <= 16'd0;
      ctrl_wdat   <= 24'd0;
      frame_done  <= 1'b0;
      frame_short <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      in_ready    <= 1'b1;
      ctrl_en     <= pix_valid;
      ctrl_wr     <= pix_valid ? WR_ALL : 4'b0000;
      frame_done  <= pix_valid && last_pix;
      // GET_R with pix_idx 0 only occurs before any pixel of the frame was taken.
      frame_short <= sof_mid || (sof_in_r && (pix_idx != 16'd0));
      if (pix_valid) begin
        ctrl_addr <= pix_idx;
        ctrl_wdat <= {reduce_ch(pix_data[23:16]), reduce_ch(pix_data[15:8]),
                      reduce_ch(pix_data[7:0])};
      end
      if (sof_start) begin
        pix_idx <= 16'd0;
      end else if (pix_valid) begin
        pix_idx <= last_pix ? 16'd0 : pix_idx + 16'd1;
      end
      if (pix_valid && last_pix) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_writer.sv
// Randomised directed bench for pixel_stream_writer, checked against a byte-counting frame model.
module tb_pixel_stream_writer;

  localparam int PIXELS = 3 * 128;

  typedef struct {
    logic [15:0] addr;
    logic [23:0] w6;
    logic [23:0] w8;
    logic        done;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_sof = 1'b0;
  logic        in_ready, ctrl_en, frame_done, frame_short;
  logic [3:0]  ctrl_wr;
  logic [15:0] ctrl_addr, frame_count;
  logic [23:0] ctrl_wdat;
  logic        rdy8, en8, done8, short8;
  logic [3:0]  wr8;
  logic [15:0] addr8, count8;
  logic [23:0] wdat8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int mcount = 0;
  bit in_frame = 1'b0;
  int nb = 0;
  logic [7:0] pb [0:2];
  wr_t exp_wr [int];
  bit  exp_short [int];
  logic [23:0] cap_w6 [0:PIXELS-1];

  pixel_stream_writer #(.CHAINED(3), .INPUT_DEPTH(6)) dut (
    .ctrl_clk(clk), .ctrl_rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sof(in_sof), .ctrl_en(ctrl_en), .ctrl_wr(ctrl_wr),
    .ctrl_addr(ctrl_addr), .ctrl_wdat(ctrl_wdat), .frame_done(frame_done),
    .frame_short(frame_short), .frame_count(frame_count));

  pixel_stream_writer #(.CHAINED(3), .INPUT_DEPTH(8)) dut8 (
    .ctrl_clk(clk), .ctrl_rst(rst), .in_valid(in_valid), .in_ready(rdy8),
    .in_data(in_data), .in_sof(in_sof), .ctrl_en(en8), .ctrl_wr(wr8),
    .ctrl_addr(addr8), .ctrl_wdat(wdat8), .frame_done(done8),
    .frame_short(short8), .frame_count(count8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [23:0] red(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b, input int d);
    int div;
    div = 1 << (8 - d);
    return {8'(int'(r) / div), 8'(int'(g) / div), 8'(int'(b) / div)};
  endfunction

  // Frame model: count bytes since the last SOF; every third byte completes a pixel.
  task automatic model_byte(input logic [7:0] d, input logic s);
    wr_t e;
    if (s) begin
      if (in_frame && nb > 0) exp_short[cyc] = 1'b1;
      in_frame = 1'b1;
      nb = 1;
      pb[0] = d;
    end else if (in_frame) begin
      pb[nb % 3] = d;
      nb++;
      if (nb % 3 == 0) begin
        e.addr = 16'(nb / 3 - 1);
        e.w6 = red(pb[0], pb[1], pb[2], 6);
        e.w8 = red(pb[0], pb[1], pb[2], 8);
        e.done = (nb / 3 == PIXELS);
        exp_wr[cyc] = e;
        if (e.done) in_frame = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      wr_t e;
      bit has;
      has = exp_wr.exists(cyc);
      chk("en", 64'(ctrl_en), 64'(has));
      chk("en8", 64'(en8), 64'(has));
      if (has) begin
        e = exp_wr[cyc];
        chk("addr", 64'(ctrl_addr), 64'(e.addr));
        chk("wr", 64'(ctrl_wr), 64'(4'b0111));
        chk("wdat", 64'(ctrl_wdat), 64'(e.w6));
        chk("wdat8", 64'(wdat8), 64'(e.w8));
        chk("done", 64'(frame_done), 64'(e.done));
        if (e.done) mcount++;
        if (e.addr < 16'(PIXELS)) cap_w6[e.addr] = ctrl_wdat;
        exp_wr.delete(cyc);
      end else begin
        chk("wr_idle", 64'(ctrl_wr), 64'd0);
        chk("done_idle", 64'(frame_done), 64'd0);
      end
      chk("short", 64'(frame_short), 64'(exp_short.exists(cyc)));
      if (exp_short.exists(cyc)) exp_short.delete(cyc);
      chk("count", 64'(frame_count), 64'(mcount));
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data = 8'($urandom);
      in_sof = 1'($urandom);
      @(posedge clk);
    end
    #1;
    in_sof = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic s, input int gap);
    logic rdy_s;
    if (gap > 0) idle(gap);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    in_sof = s;
    rdy_s = in_ready;
    @(posedge clk);
    #1;
    if (rdy_s) model_byte(d, s);
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_en"}, 64'(ctrl_en), 64'd0);
    chk({tag, "_wr"}, 64'(ctrl_wr), 64'd0);
    chk({tag, "_addr"}, 64'(ctrl_addr), 64'd0);
    chk({tag, "_wdat"}, 64'(ctrl_wdat), 64'd0);
    chk({tag, "_done"}, 64'(frame_done), 64'd0);
    chk({tag, "_short"}, 64'(frame_short), 64'd0);
    chk({tag, "_count"}, 64'(frame_count), 64'd0);
  endtask

  task automatic release_reset();
    repeat (3) @(negedge clk);
    chk("ready_in_reset", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_at_release", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", 64'(in_ready), 64'd1);
    in_frame = 1'b0;
    nb = 0;
    mon_en = 1'b1;
  endtask

  initial begin
    #1;
    check_zero("reset");
    release_reset();

    // Stream without any SOF.
    for (int i = 0; i < 20; i++) send(8'($urandom), 1'b0, 0);

    // Back-to-back full frame, byte k = k mod 256, then overrun bytes.
    for (int k = 0; k < 3 * PIXELS; k++) send(8'(k), (k == 0), 0);
    for (int i = 0; i < 9; i++) send(8'($urandom), 1'b0, 0);
    idle(3);
    chk("px0_wdat", 64'(cap_w6[0]), 64'h0);
    chk("px1_wdat", 64'(cap_w6[1]), 64'h000101);
    chk("px383_wdat", 64'(cap_w6[383]), 64'(red(8'(1149), 8'(1150), 8'(1151), 6)));
    chk("count_frame1", 64'(frame_count), 64'd1);

    // Depth reduction on pixel 0 of a frame that is cut short after 7 bytes.
    send(8'hFF, 1'b1, 0);
    send(8'h80, 1'b0, 1);
    send(8'h03, 1'b0, 0);
    chk("depth6", 64'(ctrl_wdat), 64'h3F2000);
    chk("depth8", 64'(wdat8), 64'hFF8003);
    chk("depth_addr", 64'(ctrl_addr), 64'd0);
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0, 0);
    // New SOF with R byte pending, then a second frame aborted while waiting for B.
    send(8'($urandom), 1'b1, 0);
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0, $urandom_range(0, 2));
    send(8'($urandom), 1'b1, 1);
    idle(2);
    chk("count_after_short", 64'(frame_count), 64'd1);

    // The frame just started continues with random gaps.
    for (int k = 1; k < 3 * PIXELS; k++) send(8'($urandom), 1'b0, $urandom_range(0, 2));
    idle(3);
    chk("count_frame2", 64'(frame_count), 64'd2);

    // Reset in the middle of a frame.
    send(8'($urandom), 1'b1, 0);
    for (int k = 1; k < 300; k++) send(8'($urandom), 1'b0, 0);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    exp_wr.delete();
    exp_short.delete();
    mcount = 0;
    #1;
    check_zero("midreset");
    release_reset();

    send(8'h40, 1'b1, 0);
    send(8'h80, 1'b0, 0);
    send(8'hC0, 1'b0, 0);
    chk("restart_addr", 64'(ctrl_addr), 64'd0);
    chk("restart_wdat", 64'(ctrl_wdat), 64'h102030);
    for (int k = 3; k < 30; k++) send(8'($urandom), 1'b0, $urandom_range(0, 1));
    idle(5);
    chk("pending_writes", 64'(exp_wr.size()), 64'd0);
    chk("pending_short", 64'(exp_short.size()), 64'd0);
    chk("count_final", 64'(frame_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_stream_writer.md
Name: pixel_stream_writer

Overview:
- Upstream feeder for the LED panel driver's video memory write port (ctrl_en/ctrl_wr/ctrl_addr/ctrl_wdat).
- Accepts a byte stream of RGB888 pixels with a start-of-frame marker, packs each R,G,B byte triplet into one pixel, reduces it to INPUT_DEPTH bits per channel, and issues one linear-address write per pixel.
- Reports frame completion, short frames and a frame counter for the control CPU.

Parameters:
CHAINED, 3, number of chained panels; frame holds PIXELS = CHAINED*128 pixels
INPUT_DEPTH, 6, bits per channel the video memory stores; must be 1..8

Ports:
ctrl_clk  input  1  write-side clock, shared with the panel driver's ctrl_clk
ctrl_rst  input  1  asynchronous, active-high reset
in_valid  input  1  stream byte valid
in_ready  output 1  stream byte ready
in_data   input  8  stream byte; order per pixel R, G, B
in_sof    input  1  qualifies in_data as the R byte of pixel 0 of a new frame
ctrl_en   output 1  write strobe to video memory
ctrl_wr   output 4  channel write mask; 4'b0111 when ctrl_en=1, else 4'b0000
ctrl_addr output 16 pixel index 0..PIXELS-1, zero-extended
ctrl_wdat output 24 {R,G,B} bytes, each channel right-justified: {(8-INPUT_DEPTH) zeros, byte[7:8-INPUT_DEPTH]}
frame_done  output 1  one-cycle pulse with the write of pixel PIXELS-1
frame_short output 1  one-cycle pulse when SOF aborts an incomplete frame
frame_count output 16 completed frames, wraps 16'hFFFF -> 0

Behaviour:
- One clock (ctrl_clk); reset asynchronous, active-high.
- Reset values: all outputs 0. in_ready=0 while ctrl_rst is high, then 1 from the first clock edge after release. No backpressure afterwards: in_ready stays 1.
- Accept = in_valid && in_ready.
- FSM states: WAIT_SOF, GET_R, GET_G, GET_B, DROP. Reset state is WAIT_SOF with pix_idx=0.
- Accepted byte with in_sof=1, in any state:
  - Latch R; pix_idx<=0; go to GET_G.
  - Pulse frame_short the next cycle if the state was GET_G, GET_B, or GET_R with pix_idx!=0.
  - No pulse when the state was WAIT_SOF or DROP.
- WAIT_SOF and DROP discard accepted bytes with in_sof=0.
- GET_R: latch R, go to GET_G. GET_G: latch G, go to GET_B.
- GET_B:
  - Latch B.
  - Next cycle: ctrl_en=1, ctrl_wr=4'b0111, ctrl_addr=pix_idx, ctrl_wdat formed from the latched R,G,B.
  - Write latency is exactly 1 cycle after the B byte is accepted. ctrl_en is high for exactly 1 cycle per pixel.
  - If pix_idx < PIXELS-1: increment pix_idx, go to GET_R.
  - If pix_idx == PIXELS-1: frame_done pulses in the same cycle as the write, frame_count increments, pix_idx<=0, go to DROP. Extra bytes are ignored until the next SOF.
- ctrl_addr and ctrl_wdat hold their last value while ctrl_en=0; the sink ignores them.
- A write already scheduled when SOF arrives in the same cycle still completes. The next write can only follow 3 accepted bytes later, so writes never collide.
- SOF in GET_B: the partial pixel is discarded, no write, frame_short pulses.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset mid-frame: FSM, pix_idx, pulses and frame_count clear immediately; no write is emitted after reset assertion.

Decomposition:
- Shared package holds:
  - FSM state encoding.
  - Constant WR_ALL = 4'b0111.
  - Function pixel_count(CHAINED) = CHAINED*128, also used by the panel driver.
- One natural sub-module, rgb_byte_packer: the FSM plus R/G latches, emitting a 24-bit pixel with a valid pulse and an sof-abort flag.
- The top holds pix_idx, depth reduction, write-port registers, frame_done/frame_short/frame_count.

Test Plan:
- Full frame, CHAINED=3, 1152 bytes back-to-back. Byte k = k mod 256, SOF on byte 0 -> 384 writes at addr 0..383 with ctrl_wr=4'b0111. Pixel 0 wdat = {6'h00, 6'h00, 6'h00}; pixel 1 (bytes 3,4,5) wdat = 24'h000101. frame_done pulses with the addr-383 write; frame_count=1.
- Depth reduction: pixel R=8'hFF, G=8'h80, B=8'h03 -> ctrl_wdat=24'h3F2000. With INPUT_DEPTH=8 -> 24'hFF8003.
- Short frame: SOF, 7 bytes, SOF again -> 2 writes (addr 0,1), then a frame_short pulse. The new frame restarts at addr 0; frame_count unchanged.
- Overrun and no-SOF: 20 bytes before any SOF -> no writes. After a full frame, 9 extra bytes -> no writes, no pulses.
- Gapped valid: random in_valid gaps -> same write sequence as back-to-back, each write exactly 1 cycle after its B byte.
- Reset mid-frame at pixel 100 -> outputs 0 at once. in_ready=0 during reset, 1 after release. The next SOF frame writes from addr 0; frame_count=0.
